// File: rtl/clock_pkg.sv
// Shared types and timing constants for the digital clock mode controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } clk_mode_t;

  // Cycle counts derived from the clock frequency.
  function automatic int unsigned sec_cyc_of(input int unsigned clk_hz);
    return clk_hz;
  endfunction

  function automatic int unsigned hold_cyc_of(input int unsigned clk_hz);
    return clk_hz / 2;
  endfunction

  function automatic int unsigned rpt_cyc_of(input int unsigned clk_hz);
    return clk_hz / 8;
  endfunction

  function automatic int unsigned blink_cyc_of(input int unsigned clk_hz);
    return clk_hz / 4;
  endfunction

  // Values for the production 50 MHz clock.
  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned SEC_CYC    = sec_cyc_of(DEF_CLK_HZ);
  localparam int unsigned HOLD_CYC   = hold_cyc_of(DEF_CLK_HZ);
  localparam int unsigned RPT_CYC    = rpt_cyc_of(DEF_CLK_HZ);
  localparam int unsigned BLINK_CYC  = blink_cyc_of(DEF_CLK_HZ);

endpackage

// File: rtl/clock_set_ctrl_btn_pulse.sv
// Button front end: one sync flop, rising-edge press detect and
// hold-to-repeat timer. press/rpt are combinational from local flops.
module btn_pulse
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned RPT_CYC  = 2,
  parameter bit          RPT_EN   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic cancel,
  output logic press,
  output logic rpt
);

  localparam int unsigned CW = $clog2(HOLD_CYC);

  logic          sync;
  logic          prev;
  logic          armed;
  logic [CW-1:0] cnt;

  assign press = sync & ~prev;
  assign rpt   = RPT_EN & armed & sync & (cnt == '0);

  // Sync/edge history and the repeat down-counter; release or cancel disarms.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= btn;
      prev <= sync;
      if (cancel || !sync) begin
        armed <= 1'b0;
        cnt   <= '0;
      end else if (press) begin
        armed <= 1'b1;
        cnt   <= CW'(HOLD_CYC - 1);
      end else if (rpt) begin
        cnt <= CW'(RPT_CYC - 1);
      end else if (armed) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM, 1 Hz prescaler, set-mode idle timeout and field blink timer.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic       tick_1hz,
  output logic       sec_clr,
  output logic       hour_inc,
  output logic       min_inc,
  output logic       blink,
  output logic [1:0] mode
);

  localparam int unsigned SEC_LEN   = sec_cyc_of(CLK_HZ);
  localparam int unsigned HOLD_LEN  = hold_cyc_of(CLK_HZ);
  localparam int unsigned RPT_LEN   = rpt_cyc_of(CLK_HZ);
  localparam int unsigned BLINK_LEN = blink_cyc_of(CLK_HZ);
  localparam int unsigned TO_LEN    = TIMEOUT_S * CLK_HZ;
  localparam int unsigned PW        = $clog2(SEC_LEN);
  localparam int unsigned TW        = $clog2(TO_LEN);
  localparam int unsigned BW        = $clog2(BLINK_LEN);

  clk_mode_t     state;
  clk_mode_t     state_nxt;
  logic          state_chg;
  logic          timeout;
  logic          mode_press;
  logic          mode_rpt;
  logic          inc_press;
  logic          inc_rpt;
  logic          inc_evt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] blink_cnt;

  btn_pulse #(.HOLD_CYC(HOLD_LEN), .RPT_CYC(RPT_LEN), .RPT_EN(1'b0)) u_mode_btn (
    .clk    (clk),
    .reset  (reset),
    .btn    (mode_btn),
    .cancel (state_chg),
    .press  (mode_press),
    .rpt    (mode_rpt)
  );

  btn_pulse #(.HOLD_CYC(HOLD_LEN), .RPT_CYC(RPT_LEN), .RPT_EN(1'b1)) u_inc_btn (
    .clk    (clk),
    .reset  (reset),
    .btn    (inc_btn),
    .cancel (state_chg),
    .press  (inc_press),
    .rpt    (inc_rpt)
  );

  assign inc_evt   = inc_press | inc_rpt;
  assign timeout   = (state != RUN) && (to_cnt == TW'(TO_LEN - 1));
  assign state_chg = (state_nxt != state);
  assign mode      = state;

  // Prescaler only advances while staying in RUN, so leaving RUN never ticks.
  assign presc_nxt = (state == RUN && state_nxt == RUN)
                   ? ((presc == PW'(SEC_LEN - 1)) ? '0 : presc + 1'b1)
                   : '0;

  // Next state: timeout beats a mode press; mode press cycles the set states.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = RUN;
    end else if (mode_press) begin
      case (state)
        RUN:      state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  // State register and registered pulse/level outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      tick_1hz <= 1'b0;
      sec_clr  <= 1'b0;
      hour_inc <= 1'b0;
      min_inc  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_1hz <= (presc_nxt == PW'(SEC_LEN - 1));
      sec_clr  <= (state_nxt != RUN);
      hour_inc <= !state_chg && (state == SET_HOUR) && inc_evt;
      min_inc  <= !state_chg && (state == SET_MIN) && inc_evt;
    end
  end

  // Prescaler, idle timeout and blink timers.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      to_cnt    <= '0;
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      presc <= presc_nxt;

      if (state == RUN || state_chg || inc_evt || mode_press || mode_rpt) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state_nxt == RUN) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (state_chg) begin
        blink     <= 1'b1;
        blink_cnt <= BW'(BLINK_LEN - 1);
      end else if (blink_cnt == '0) begin
        blink     <= ~blink;
        blink_cnt <= BW'(BLINK_LEN - 1);
      end else begin
        blink_cnt <= blink_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl at CLK_HZ=16, TIMEOUT_S=2.
module tb_clock_set_ctrl;

  localparam int K_TICK = 0;
  localparam int K_HOUR = 1;
  localparam int K_MIN  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       tick_1hz;
  logic       sec_clr;
  logic       hour_inc;
  logic       min_inc;
  logic       blink;
  logic [1:0] mode;

  clock_set_ctrl #(.CLK_HZ(16), .TIMEOUT_S(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .tick_1hz (tick_1hz),
    .sec_clr  (sec_clr),
    .hour_inc (hour_inc),
    .min_inc  (min_inc),
    .blink    (blink),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int kind;
    int at;
  } exp_t;
  exp_t sbq[$];
  bit track_tick = 1'b0;

  typedef struct {
    logic       m;
    logic       i;
    int         kind;
    logic [1:0] exp_mode;
    logic       exp_clr;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic take(input int kind);
    exp_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_pulse: kind %0d at cycle %0d, want none", kind, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        miscompares++;
        $display("FAIL pulse: kind %0d at cycle %0d, want kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.at);
      end
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (hour_inc) take(K_HOUR);
      if (min_inc) take(K_MIN);
      if (tick_1hz && track_tick) take(K_TICK);
      if (tick_1hz && mode != 2'b00) begin
        vectors++;
        miscompares++;
        $display("FAIL tick_in_set: tick_1hz 1 with mode %0d, want 0", mode);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic mode_pulse();
    mode_btn = 1'b1;
    step(1);
    mode_btn = 1'b0;
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int k;
    int e;

    tbl[0] = '{1'b0, 1'b1, 0,      2'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 0,      2'd1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, K_HOUR, 2'd1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, K_HOUR, 2'd1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 0,      2'd2, 1'b1};
    tbl[5] = '{1'b0, 1'b1, K_MIN,  2'd2, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 0,      2'd0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 0,      2'd1, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 0,      2'd2, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 0,      2'd0, 1'b0};

    // Reset values, then idle ticks every 16 cycles.
    step(3);
    check("rst_mode", mode, 0);
    check("rst_tick", tick_1hz, 0);
    check("rst_sec_clr", sec_clr, 0);
    check("rst_hour_inc", hour_inc, 0);
    check("rst_min_inc", min_inc, 0);
    check("rst_blink", blink, 0);
    reset = 1'b0;
    r = cyc;
    for (int t = 1; t <= 4; t++) sbq.push_back('{K_TICK, r + 16 * t - 1});
    track_tick = 1'b1;
    wait_until(r + 40);
    check("idle_sec_clr", sec_clr, 0);
    check("idle_mode", mode, 0);
    wait_until(r + 64);
    track_tick = 1'b0;
    check("idle_ticks_drained", sbq.size(), 0);

    // Single-press table walking through the modes.
    for (int v = 0; v < 10; v++) begin
      k = cyc;
      mode_btn = tbl[v].m;
      inc_btn = tbl[v].i;
      if (tbl[v].kind != 0) sbq.push_back('{tbl[v].kind, k + 2});
      step(1);
      mode_btn = 1'b0;
      inc_btn = 1'b0;
      step(5);
      check($sformatf("vec%0d_mode", v), mode, tbl[v].exp_mode);
      check($sformatf("vec%0d_sec_clr", v), sec_clr, tbl[v].exp_clr);
    end
    check("table_drained", sbq.size(), 0);

    // Mode latency, blink phase, then one hour increment.
    k = cyc;
    mode_btn = 1'b1;
    step(1);
    mode_btn = 1'b0;
    check("mode_latency_early", mode, 0);
    step(1);
    e = k + 2;
    check("mode_latency", mode, 1);
    check("set_sec_clr", sec_clr, 1);
    check("blink_entry", blink, 1);
    wait_until(e + 3);
    check("blink_e3", blink, 1);
    wait_until(e + 4);
    check("blink_e4", blink, 0);
    wait_until(e + 7);
    check("blink_e7", blink, 0);
    wait_until(e + 8);
    check("blink_e8", blink, 1);
    k = cyc;
    inc_btn = 1'b1;
    sbq.push_back('{K_HOUR, k + 2});
    step(1);
    inc_btn = 1'b0;
    step(4);
    check("hour_drained", sbq.size(), 0);

    // Held inc in SET_MIN: press, hold repeat, fast repeats, stop on release.
    mode_pulse();
    check("setmin_mode", mode, 2);
    k = cyc;
    inc_btn = 1'b1;
    sbq.push_back('{K_MIN, k + 2});
    sbq.push_back('{K_MIN, k + 10});
    sbq.push_back('{K_MIN, k + 12});
    sbq.push_back('{K_MIN, k + 14});
    step(14);
    inc_btn = 1'b0;
    step(8);
    check("repeat_drained", sbq.size(), 0);

    // Idle timeout out of SET_HOUR, then first tick 16 cycles after entry to RUN.
    mode_pulse();
    check("back_to_run", mode, 0);
    k = cyc;
    mode_btn = 1'b1;
    step(1);
    mode_btn = 1'b0;
    e = k + 2;
    wait_until(e + 31);
    check("timeout_not_yet", mode, 1);
    wait_until(e + 32);
    check("timeout_mode", mode, 0);
    check("timeout_sec_clr", sec_clr, 0);
    check("timeout_blink", blink, 0);
    sbq.push_back('{K_TICK, e + 47});
    track_tick = 1'b1;
    wait_until(e + 48);
    track_tick = 1'b0;
    check("timeout_tick_drained", sbq.size(), 0);

    // Reset in SET_MIN with inc held.
    mode_pulse();
    mode_pulse();
    check("pre_reset_mode", mode, 2);
    k = cyc;
    inc_btn = 1'b1;
    sbq.push_back('{K_MIN, k + 2});
    step(4);
    reset = 1'b1;
    step(1);
    check("midrst_mode", mode, 0);
    check("midrst_sec_clr", sec_clr, 0);
    check("midrst_blink", blink, 0);
    check("midrst_min_inc", min_inc, 0);
    check("midrst_tick", tick_1hz, 0);
    step(2);
    reset = 1'b0;
    step(1);
    check("postrst_mode", mode, 0);
    check("postrst_hour_inc", hour_inc, 0);
    check("postrst_min_inc", min_inc, 0);
    step(20);
    check("postrst_mode_late", mode, 0);
    check("postrst_sec_clr", sec_clr, 0);
    inc_btn = 1'b0;
    step(2);
    check("final_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
